// File: rtl/ram_arb_pkg.sv
// Shared types, RAM geometry and round-robin search for the RAM arbiters.
// Latency: n/a (package only).
// Backpressure: n/a.
package ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;

    localparam int RAM_AW  = 8;
    localparam int RAM_DW  = 16;
    localparam int MAX_REQ = 8;

    // First set bit of req searching ptr+1, ptr+2, ... modulo n; returns ptr when req is empty.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0] ptr,
                                           input int n);
        logic [2:0] win;
        int         c;
        win = ptr;
        // Walk from the farthest candidate inward so the nearest one overwrites last.
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                c = (int'(ptr) + k) % n;
                if (req[c[2:0]]) begin
                    win = c[2:0];
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin grant: one-hot gnt, its index and an any-request flag.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides whether the grant is used.
module rr_picker
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    logic [MAX_REQ-1:0] req_ext;
    logic [2:0]         win;

    always_comb begin
        req_ext = MAX_REQ'(req);
        win     = rr_pick(req_ext, 3'(ptr), NREQ);
        gnt_idx = IW'(win);
        any     = |req;
        gnt     = '0;
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin sharing of one synchronous RAM between NREQ requesters, one op in flight.
// Latency: RAM strobe one cycle after accept, read response two cycles after accept.
// Backpressure: req_ready only in IDLE, to the round-robin winner; no ready while an op is in flight.
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = RAM_AW,
    parameter int DW   = RAM_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ-1:0]  req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [DW-1:0]    rsp_data,
    output logic             ram_read,
    output logic             ram_write,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_wdata,
    input  logic [DW-1:0]    ram_rdata
);

    localparam int IW = $clog2(NREQ);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    arb_state_t      state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            any;
    logic            we_q;
    logic [DW-1:0]   rdata_q;
    req_t            sel;

    rr_picker #(.NREQ(NREQ)) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        sel = '{we:    req_we[gnt_idx],
                addr:  req_addr[gnt_idx*AW +: AW],
                wdata: req_wdata[gnt_idx*DW +: DW]};
    end

    assign req_ready = (state == IDLE) ? gnt : '0;
    // The RAM output register is only valid during RESP; otherwise replay the last response.
    assign rsp_data  = (state == RESP) ? ram_rdata : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IW'(NREQ - 1);
            owner     <= '0;
            we_q      <= 1'b0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rsp_valid <= '0;
            rdata_q   <= '0;
        end else begin
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        owner     <= gnt_idx;
                        ptr       <= gnt_idx;
                        we_q      <= sel.we;
                        ram_addr  <= sel.addr;
                        ram_wdata <= sel.wdata;
                        ram_read  <= ~sel.we;
                        ram_write <= sel.we;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state <= IDLE;
                    end else begin
                        rsp_valid[owner] <= 1'b1;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    rdata_q <= ram_rdata;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(ram_read && ram_write));
    a_ready_1hot:  assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_rsp_1hot:    assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
    a_rsp_after_rd: assert property (@(posedge clk) disable iff (rst) (rsp_valid != '0) |-> $past(ram_read));

endmodule
